// File: rtl/shell_pkg.sv
// Shared AXI4-Lite constants and types for the zedboard shell.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package shell_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = 4;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

    // Merge new_w into old_w one byte lane at a time, taking lane k from new_w iff strb[k]
    function automatic logic [AXIL_DATA_W-1:0] apply_strb(
        input logic [AXIL_DATA_W-1:0] old_w,
        input logic [AXIL_DATA_W-1:0] new_w,
        input logic [AXIL_STRB_W-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] res;
        res = old_w;
        for (int k = 0; k < AXIL_STRB_W; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave: CTRL_NUM R/W control registers followed by STAT_NUM read-only status words.
// Latency: write commit and read data both visible one cycle after the completing handshake.
// Backpressure: one outstanding write and one outstanding read; ready stays low while a response waits.
module axil_reg_bank
    import shell_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int CTRL_NUM   = 16,
    parameter int STAT_NUM   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    s_axil_awaddr,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [31:0]              s_axil_wdata,
    input  logic [3:0]               s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,
    output logic [CTRL_NUM*32-1:0]   ctrl_o,
    output logic [CTRL_NUM-1:0]      ctrl_wr_o,
    input  logic [STAT_NUM*32-1:0]   stat_i
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] CTRL_LIM = IDX_W'(CTRL_NUM);

    // Byte offset bits carry no meaning for word-wide registers
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    // Ready gate: low through reset, high from the first cycle after reset releases
    logic rdy_en_q, rdy_en_d;

    // Write path state
    logic                   aw_held_q, aw_held_d;
    logic [IDX_W-1:0]       aw_idx_q, aw_idx_d;
    logic                   w_held_q, w_held_d;
    logic [AXIL_DATA_W-1:0] w_data_q, w_data_d;
    logic [AXIL_STRB_W-1:0] w_strb_q, w_strb_d;
    logic                   bvalid_q, bvalid_d;
    axi_resp_t              bresp_q, bresp_d;
    logic [AXIL_DATA_W-1:0] ctrl_q [CTRL_NUM];
    logic [AXIL_DATA_W-1:0] ctrl_d [CTRL_NUM];
    logic [CTRL_NUM-1:0]    ctrl_wr_q, ctrl_wr_d;

    // Read path state
    logic                   rvalid_q, rvalid_d;
    logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;
    axi_resp_t              rresp_q, rresp_d;

    logic                   aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]       cm_idx, ar_idx;
    logic [AXIL_DATA_W-1:0] cm_data;
    logic [AXIL_STRB_W-1:0] cm_strb;

    assign s_axil_awready = rdy_en_q && !aw_held_q && !bvalid_q;
    assign s_axil_wready  = rdy_en_q && !w_held_q && !bvalid_q;
    assign s_axil_arready = rdy_en_q && !rvalid_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign ctrl_wr_o      = ctrl_wr_q;

    for (genvar g = 0; g < CTRL_NUM; g++) begin : g_ctrl_out
        assign ctrl_o[32*g +: 32] = ctrl_q[g];
    end

    assign aw_hs  = s_axil_awvalid && s_axil_awready;
    assign w_hs   = s_axil_wvalid && s_axil_wready;
    assign ar_hs  = s_axil_arvalid && s_axil_arready;
    // Commit once both halves are in hand, whether held from earlier or arriving now
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign cm_idx  = aw_held_q ? aw_idx_q : s_axil_awaddr[ADDR_WIDTH-1:2];
    assign cm_data = w_held_q ? w_data_q : s_axil_wdata;
    assign cm_strb = w_held_q ? w_strb_q : s_axil_wstrb;
    assign ar_idx  = s_axil_araddr[ADDR_WIDTH-1:2];

    // Write path: latch AW/W halves, commit into the register array, drive the B channel
    always_comb begin
        rdy_en_d  = 1'b1;
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        ctrl_wr_d = '0;

        if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (cm_idx < CTRL_LIM) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            for (int i = 0; i < CTRL_NUM; i++) begin
                if (cm_idx == IDX_W'(i)) begin
                    ctrl_d[i]    = apply_strb(ctrl_q[i], cm_data, cm_strb);
                    ctrl_wr_d[i] = 1'b1;
                end
            end
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = s_axil_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = s_axil_wdata;
                w_strb_d = s_axil_wstrb;
            end
        end
    end

    // Read path: decode AR and register the response; control reads see the pre-commit value
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = AXI_RESP_SLVERR;
            for (int i = 0; i < CTRL_NUM; i++) begin
                if (ar_idx == IDX_W'(i)) begin
                    rdata_d = ctrl_q[i];
                    rresp_d = AXI_RESP_OKAY;
                end
            end
            for (int j = 0; j < STAT_NUM; j++) begin
                if (ar_idx == IDX_W'(CTRL_NUM + j)) begin
                    rdata_d = stat_i[32*j +: 32];
                    rresp_d = AXI_RESP_OKAY;
                end
            end
        end
    end

    // State registers; reset discards any half-received or unacknowledged transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_en_q  <= 1'b0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            ctrl_wr_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= AXI_RESP_OKAY;
            for (int i = 0; i < CTRL_NUM; i++) begin
                ctrl_q[i] <= '0;
            end
        end else begin
            rdy_en_q  <= rdy_en_d;
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            ctrl_wr_q <= ctrl_wr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ctrl_q    <= ctrl_d;
        end
    end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed testbench for axil_reg_bank with CTRL_NUM=16, STAT_NUM=4.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Every wait on the DUT is bounded; timeouts show up as wrong captured values.
module tb_axil_reg_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [11:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [511:0] ctrl_o;
    logic [15:0]  ctrl_wr_o;
    logic [127:0] stat_i;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    axil_reg_bank #(.ADDR_WIDTH(12), .CTRL_NUM(16), .STAT_NUM(4)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .ctrl_o(ctrl_o), .ctrl_wr_o(ctrl_wr_o), .stat_i(stat_i)
    );

    always #5 clk = ~clk;

    // Count every ctrl_wr_o bit seen high, once per cycle
    always @(negedge clk) begin
        if (!rst) pulse_cnt += $countones(ctrl_wr_o);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full write transaction; resp is 2'bxx if the DUT never responds
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_now, w_now;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            cyc();
            if (aw_now) awvalid = 1'b0;
            if (w_now)  wvalid  = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        for (int n = 0; n < 20 && !bvalid; n++) cyc();
        resp = bvalid ? bresp : 2'bxx;
        bready = 1'b1;
        cyc();
        bready = 1'b0;
    endtask

    // Full read transaction; data/resp are x if the DUT never responds
    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        araddr = a;
        arvalid = 1'b1;
        for (int n = 0; n < 20 && !arready; n++) cyc();
        cyc();
        arvalid = 1'b0;
        for (int n = 0; n < 20 && !rvalid; n++) cyc();
        d    = rvalid ? rdata : 32'hxxxxxxxx;
        resp = rvalid ? rresp : 2'bxx;
        rready = 1'b1;
        cyc();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc(); cyc();
        checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", {awready, wready, arready}); end
        checks++; if ({bvalid, rvalid} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", {bvalid, rvalid}); end
        checks++; if ({bresp, rresp, rdata} !== 36'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", {bresp, rresp, rdata}); end
        checks++; if (ctrl_o !== 512'h0 || ctrl_wr_o !== 16'h0) begin errors++; $display("FAIL reset_ctrl: ctrl_wr %h want 0000", ctrl_wr_o); end
        rst = 1'b0;
        cyc();
        checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL ready_after_reset: got %b want 111", {awready, wready, arready}); end
    endtask

    task automatic test_basic_write();
        awaddr = 12'h004; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL bw_ready: got %b want 11", {awready, wready}); end
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++; if (ctrl_o[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL bw_reg1: got %h want DEADBEEF", ctrl_o[63:32]); end
        checks++; if (ctrl_wr_o !== 16'h0002) begin errors++; $display("FAIL bw_pulse: got %h want 0002", ctrl_wr_o); end
        checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL bw_b: got bvalid %b bresp %b want 1 00", bvalid, bresp); end
        checks++; if (awready !== 1'b0) begin errors++; $display("FAIL bw_awready_busy: got %b want 0", awready); end
        cyc();
        checks++; if (ctrl_wr_o !== 16'h0000) begin errors++; $display("FAIL bw_pulse_end: got %h want 0000", ctrl_wr_o); end
        checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL bw_bhold: got %b want 1", bvalid); end
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        checks++; if (bvalid !== 1'b0 || awready !== 1'b1) begin errors++; $display("FAIL bw_bdone: got bvalid %b awready %b want 0 1", bvalid, awready); end
    endtask

    task automatic test_strb_and_read();
        logic [1:0] r;
        axi_write(12'h008, 32'h11223344, 4'hF, r);
        checks++; if (r !== 2'b00) begin errors++; $display("FAIL strb_full_resp: got %b want 00", r); end
        axi_write(12'h008, 32'hAABBCCDD, 4'h5, r);
        checks++; if (ctrl_o[95:64] !== 32'h11BB33DD) begin errors++; $display("FAIL strb_merge: got %h want 11BB33DD", ctrl_o[95:64]); end
        araddr = 12'h008; arvalid = 1'b1;
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rd_arready: got %b want 1", arready); end
        cyc();
        arvalid = 1'b0;
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h11BB33DD || rresp !== 2'b00) begin errors++; $display("FAIL rd_lat1: got rvalid %b rdata %h rresp %b want 1 11BB33DD 00", rvalid, rdata, rresp); end
        rready = 1'b1;
        cyc();
        rready = 1'b0;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rd_done: got %b want 0", rvalid); end
    endtask

    task automatic test_w_aw_order();
        int cnt0;
        cnt0 = pulse_cnt;
        // W three cycles ahead of AW, register 3
        wdata = 32'h0000A5A5; wstrb = 4'hF; wvalid = 1'b1;
        cyc();
        wvalid = 1'b0;
        checks++; if (wready !== 1'b0 || bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_held: got wready %b bvalid %b want 0 0", wready, bvalid); end
        cyc(); cyc();
        awaddr = 12'h00C; awvalid = 1'b1;
        cyc();
        awvalid = 1'b0;
        checks++; if (ctrl_o[127:96] !== 32'h0000A5A5 || bvalid !== 1'b1) begin errors++; $display("FAIL wfirst_commit: got %h bvalid %b want 0000A5A5 1", ctrl_o[127:96], bvalid); end
        for (int k = 0; k < 5; k++) begin
            checks++; if ({awready, wready, bvalid, bresp} !== 5'b00100) begin errors++; $display("FAIL bstall_%0d: got %b want 00100", k, {awready, wready, bvalid, bresp}); end
            cyc();
        end
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        checks++; if (pulse_cnt - cnt0 !== 1) begin errors++; $display("FAIL wfirst_one_commit: got %0d want 1", pulse_cnt - cnt0); end
        // AW ahead of W, register 4
        awaddr = 12'h010; awvalid = 1'b1;
        cyc();
        awvalid = 1'b0;
        checks++; if (awready !== 1'b0 || wready !== 1'b1) begin errors++; $display("FAIL awfirst_held: got awready %b wready %b want 0 1", awready, wready); end
        cyc();
        wdata = 32'h5A5A0000; wvalid = 1'b1;
        cyc();
        wvalid = 1'b0;
        checks++; if (ctrl_o[159:128] !== 32'h5A5A0000 || bvalid !== 1'b1) begin errors++; $display("FAIL awfirst_commit: got %h bvalid %b want 5A5A0000 1", ctrl_o[159:128], bvalid); end
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        checks++; if (pulse_cnt - cnt0 !== 2) begin errors++; $display("FAIL awfirst_one_commit: got %0d want 2", pulse_cnt - cnt0); end
    endtask

    task automatic test_status();
        logic [31:0] d;
        logic [1:0] r;
        logic [511:0] snap;
        int cnt0;
        stat_i = {32'h12345678, 32'h0, 32'h0, 32'hCAFE0001};
        axi_read(12'h040, d, r);
        checks++; if (d !== 32'hCAFE0001 || r !== 2'b00) begin errors++; $display("FAIL stat0_read: got %h %b want CAFE0001 00", d, r); end
        axi_read(12'h04C, d, r);
        checks++; if (d !== 32'h12345678 || r !== 2'b00) begin errors++; $display("FAIL stat3_read: got %h %b want 12345678 00", d, r); end
        snap = ctrl_o;
        cnt0 = pulse_cnt;
        axi_write(12'h040, 32'hFFFFFFFF, 4'hF, r);
        checks++; if (r !== 2'b10) begin errors++; $display("FAIL stat_write_resp: got %b want 10", r); end
        checks++; if (ctrl_o !== snap || pulse_cnt !== cnt0) begin errors++; $display("FAIL stat_write_effect: pulses %0d want %0d", pulse_cnt, cnt0); end
        axi_write(12'h0FC, 32'hFFFFFFFF, 4'hF, r);
        checks++; if (r !== 2'b10 || ctrl_o !== snap) begin errors++; $display("FAIL oor_write: got %b want 10", r); end
    endtask

    task automatic test_oor_read();
        araddr = 12'h0FC; arvalid = 1'b1;
        cyc();
        arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if ({rvalid, rresp, rdata, arready} !== {1'b1, 2'b10, 32'h0, 1'b0}) begin errors++; $display("FAIL oor_read_%0d: got rvalid %b rresp %b rdata %h arready %b want 1 10 0 0", k, rvalid, rresp, rdata, arready); end
            cyc();
        end
        rready = 1'b1;
        cyc();
        rready = 1'b0;
        checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL oor_read_done: got %b %b want 0 1", rvalid, arready); end
    endtask

    task automatic test_same_cycle_rw();
        logic [31:0] d;
        logic [1:0] r;
        awaddr = 12'h014; wdata = 32'h00000077; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 12'h014; arvalid = 1'b1;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL rw_old_value: got %b %h want 1 00000000", rvalid, rdata); end
        checks++; if (ctrl_o[191:160] !== 32'h77) begin errors++; $display("FAIL rw_new_reg: got %h want 00000077", ctrl_o[191:160]); end
        bready = 1'b1; rready = 1'b1;
        cyc();
        bready = 1'b0; rready = 1'b0;
        axi_read(12'h014, d, r);
        checks++; if (d !== 32'h77 || r !== 2'b00) begin errors++; $display("FAIL rw_later_read: got %h %b want 00000077 00", d, r); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        awaddr = 12'h018; awvalid = 1'b1;
        araddr = 12'h000; arvalid = 1'b1;
        cyc();
        awvalid = 1'b0; arvalid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b0) begin errors++; $display("FAIL midrst_flags: got %b want 00000", {bvalid, rvalid, awready, wready, arready}); end
        checks++; if (ctrl_o !== 512'h0 || ctrl_wr_o !== 16'h0) begin errors++; $display("FAIL midrst_ctrl: reg1 %h want 0", ctrl_o[63:32]); end
        cyc();
        // A W alone must not complete against the address dropped by reset
        wdata = 32'h0BAD0BAD; wstrb = 4'hF; wvalid = 1'b1;
        cyc();
        wvalid = 1'b0;
        checks++; if (bvalid !== 1'b0 || ctrl_o[223:192] !== 32'h0) begin errors++; $display("FAIL midrst_stale_aw: got bvalid %b reg6 %h want 0 0", bvalid, ctrl_o[223:192]); end
        awaddr = 12'h01C; awvalid = 1'b1;
        cyc();
        awvalid = 1'b0;
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        axi_write(12'h018, 32'h00000099, 4'hF, r);
        checks++; if (r !== 2'b00 || ctrl_o[223:192] !== 32'h99) begin errors++; $display("FAIL midrst_fresh: got %b %h want 00 00000099", r, ctrl_o[223:192]); end
        checks++; if (ctrl_o[255:224] !== 32'h0BAD0BAD) begin errors++; $display("FAIL midrst_pair: got %h want 0BAD0BAD", ctrl_o[255:224]); end
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0; stat_i = '0;
        #1;
        test_reset();
        test_basic_write();
        test_strb_and_read();
        test_w_aw_order();
        test_status();
        test_oor_read();
        test_same_cycle_rw();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
